// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
// FSM states, grant ids, rw and size codes, plus the round-robin pick.
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       rw;
    logic [1:0] size;
  } mem_ctl_t;

  // On contention the requester that did not win last time goes next.
  function automatic logic pick_grant(
    input logic if_req,
    input logic d_req,
    input logic last
  );
    logic g;
    unique case (1'b1)
      (if_req && d_req):  g = ~last;
      (!if_req && d_req): g = GNT_D;
      default:            g = GNT_IF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the arbiter.
// master is the arbiter itself, slave is the surrounding datapath/memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_data;

  logic          d_req;
  logic          d_rw;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_mov;
  logic          mem_rw;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_moc;

  logic          err;
  logic          busy;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_data,
    input  d_req, d_rw, d_size, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_mov, mem_rw, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_moc,
    output err, busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_data,
    output d_req, d_rw, d_size, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_mov, mem_rw, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_moc,
    input  err, busy
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts wait cycles while an access is outstanding.
// expire is high once the count reaches TIMEOUT-1.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data paths.
// Round-robin on contention, MOV/MOC handshake with a timeout escape.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          grant_q;
  logic          grant_d;
  logic          last_q;
  logic          take;
  logic          done;
  logic          expire;
  mem_ctl_t      ctl_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_data_q;
  logic [DW-1:0] d_rdata_q;
  logic [DW-1:0] rdata_d;
  logic          mov_q;
  logic          busy_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic          err_q;

  assign take = (state_q == S_IDLE)
             && (bus.if_req || bus.d_req);
  assign done = (state_d == S_ACK)
             || (state_d == S_ERR);
  assign rdata_d = (state_d == S_ERR)
                 ? '0 : bus.mem_rdata;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != S_ISSUE),
    .enable (state_q == S_ISSUE && !bus.mem_moc),
    .expire (expire)
  );

  // MOC is checked before expire so a coincident MOC completes normally.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_ISSUE;
          grant_d = pick_grant(bus.if_req,
                               bus.d_req, last_q);
        end
      end
      S_ISSUE: begin
        if (bus.mem_moc) begin
          state_d = S_ACK;
        end else if (expire) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= GNT_IF;
      last_q   <= GNT_D;
      mov_q    <= 1'b0;
      busy_q   <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      if (take) begin
        last_q <= grant_d;
      end
      mov_q    <= (state_d == S_ISSUE);
      busy_q   <= (state_d != S_IDLE);
      if_ack_q <= done && (grant_q == GNT_IF);
      d_ack_q  <= done && (grant_q == GNT_D);
      err_q    <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ctl_q   <= '0;
    end else if (take) begin
      if (grant_d == GNT_IF) begin
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        ctl_q   <= '{rw: RW_READ, size: SZ_WORD};
      end else begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        ctl_q   <= '{rw: bus.d_rw, size: bus.d_size};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else if (done && ctl_q.rw == RW_READ) begin
      if (grant_q == GNT_IF) begin
        if_data_q <= rdata_d;
      end else begin
        d_rdata_q <= rdata_d;
      end
    end
  end

  assign bus.mem_mov   = mov_q;
  assign bus.mem_rw    = ctl_q.rw;
  assign bus.mem_size  = ctl_q.size;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_data   = if_data_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a
// transaction-level model of the shared memory port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef enum int {P_IDLE, P_ACT, P_GAP} phase_e;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;

  phase_e      phase;
  int          k;
  int          dly;
  int          t_end;
  int          req_mode;
  logic        win;
  logic        last_win;
  logic        x_err;
  logic        x_rw;
  logic [1:0]  x_size;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [31:0] x_cap;
  logic [31:0] x_if_data;
  logic [31:0] x_d_rdata;
  logic        win_log[$];
  int          dly_q[$];
  logic [31:0] rd_q[$];

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic raise_if(input logic [31:0] a);
    bus.if_req = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic raise_d(input logic rw,
                         input logic [1:0] sz,
                         input logic [31:0] a,
                         input logic [31:0] w);
    bus.d_req = 1'b1;
    bus.d_rw = rw;
    bus.d_size = sz;
    bus.d_addr = a;
    bus.d_wdata = w;
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    last_win = GNT_D;
    x_if_data = '0;
    x_d_rdata = '0;
    k = 0;
    t_end = 0;
    dly = 0;
  endtask

  // One clock: check the cycle, then drive the next one.
  task automatic step();
    logic pif;
    logic pd;
    logic act;
    logic e_ack;
    @(posedge clk);
    #1;
    pif = bus.if_req;
    pd = bus.d_req;
    case (phase)
      P_IDLE: begin
        if (pif || pd) begin
          if (pif && pd)
            win = (last_win == GNT_D) ? GNT_IF : GNT_D;
          else
            win = pd ? GNT_D : GNT_IF;
          last_win = win;
          win_log.push_back(win);
          if (win == GNT_IF) begin
            x_addr = bus.if_addr;
            x_wdata = '0;
            x_rw = RW_READ;
            x_size = SZ_WORD;
          end else begin
            x_addr = bus.d_addr;
            x_wdata = bus.d_wdata;
            x_rw = bus.d_rw;
            x_size = bus.d_size;
          end
          if (dly_q.size() != 0)
            dly = dly_q.pop_front();
          else
            dly = int'($urandom_range(1, 6));
          x_err = (dly > TO);
          t_end = (x_err ? TO : dly) + 1;
          k = 1;
          phase = P_ACT;
        end
      end
      P_ACT: k++;
      default: phase = P_IDLE;
    endcase
    act = (phase == P_ACT);
    e_ack = act && (k == t_end);
    check_eq("mem_mov", bus.mem_mov, act && k < t_end);
    check_eq("busy", bus.busy, act);
    check_eq("if_ack", bus.if_ack, e_ack && win == GNT_IF);
    check_eq("d_ack", bus.d_ack, e_ack && win == GNT_D);
    check_eq("err", bus.err, e_ack && x_err);
    if (act) begin
      check_eq("mem_addr", bus.mem_addr, x_addr);
      check_eq("mem_rw", bus.mem_rw, x_rw);
      check_eq("mem_size", bus.mem_size, x_size);
      check_eq("mem_wdata", bus.mem_wdata, x_wdata);
    end
    if (e_ack) begin
      if (x_rw == RW_READ) begin
        if (win == GNT_IF) x_if_data = x_err ? '0 : x_cap;
        else x_d_rdata = x_err ? '0 : x_cap;
      end
      if (win == GNT_IF) bus.if_req = 1'b0;
      else bus.d_req = 1'b0;
      n_done++;
      phase = P_GAP;
    end
    check_eq("if_data", bus.if_data, x_if_data);
    check_eq("d_rdata", bus.d_rdata, x_d_rdata);
    if (bus.err) n_err++;
    if (phase == P_ACT && k < t_end) begin
      bus.mem_moc = (k == dly);
      if (k == dly && rd_q.size() != 0)
        bus.mem_rdata = rd_q.pop_front();
      else
        bus.mem_rdata = $urandom;
      if (k == dly) x_cap = bus.mem_rdata;
      // Latched fields must survive the requester wiggling its inputs.
      if (win == GNT_IF) begin
        bus.if_addr = $urandom;
      end else begin
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
        bus.d_rw = 1'($urandom);
        bus.d_size = 2'($urandom);
      end
    end else begin
      bus.mem_moc = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
    end
    if (!e_ack && req_mode != 0) begin
      if (!bus.if_req &&
          (req_mode == 2 || $urandom_range(0, 2) == 0))
        raise_if($urandom);
      if (!bus.d_req &&
          (req_mode == 2 || $urandom_range(0, 2) == 0))
        raise_d(1'($urandom),
                2'($urandom_range(0, 2)),
                $urandom, $urandom);
    end
  endtask

  task automatic wait_done(input int target,
                           input int budget);
    int n;
    n = 0;
    while (n_done < target && n < budget) begin
      step();
      n++;
    end
    if (n_done < target)
      check_eq("wait_budget", n_done, target);
    step();
  endtask

  initial begin
    int base;
    int e0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_rw = 1'b0;
    bus.d_size = '0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_moc = 1'b0;
    req_mode = 0;
    x_cap = '0;
    model_reset();

    #1 reset = 1'b0;
    #11;
    check_eq("rst_mov", bus.mem_mov, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_if_ack", bus.if_ack, 1'b0);
    check_eq("rst_d_ack", bus.d_ack, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_if_data", bus.if_data, 32'h0);
    check_eq("rst_d_rdata", bus.d_rdata, 32'h0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    check_eq("rst_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    dly_q.push_back(3);
    rd_q.push_back(32'h8C220004);
    raise_if(32'h10);
    wait_done(1, 20);
    check_eq("fetch_data", bus.if_data, 32'h8C220004);
    check_eq("fetch_rw", bus.mem_rw, RW_READ);
    check_eq("fetch_size", bus.mem_size, SZ_WORD);

    dly_q.push_back(1);
    raise_if(32'h14);
    wait_done(2, 20);

    dly_q.push_back(2);
    rd_q.push_back(32'h12345678);
    raise_d(RW_READ, SZ_HALF, 32'h80, 32'h0);
    wait_done(3, 20);
    check_eq("ld_data", bus.d_rdata, 32'h12345678);

    dly_q.push_back(2);
    raise_d(RW_WRITE, SZ_BYTE, 32'h40, 32'hAB);
    wait_done(4, 20);
    check_eq("st_rw", bus.mem_rw, RW_WRITE);
    check_eq("st_size", bus.mem_size, SZ_BYTE);
    check_eq("st_wdata", bus.mem_wdata, 32'hAB);
    check_eq("st_keep", bus.d_rdata, 32'h12345678);

    e0 = n_err;
    dly_q.push_back(7);
    raise_d(RW_READ, SZ_WORD, 32'h100, 32'h0);
    wait_done(5, 20);
    check_eq("to_err", n_err, e0 + 1);
    check_eq("to_data", bus.d_rdata, 32'h0);

    dly_q.push_back(2);
    rd_q.push_back(32'hCAFEF00D);
    raise_d(RW_READ, SZ_WORD, 32'h104, 32'h0);
    wait_done(6, 20);
    check_eq("after_to", bus.d_rdata, 32'hCAFEF00D);

    dly_q.push_back(TO);
    rd_q.push_back(32'h600DF00D);
    raise_if(32'h200);
    wait_done(7, 20);
    check_eq("coin_data", bus.if_data, 32'h600DF00D);
    check_eq("coin_err", n_err, e0 + 1);

    dly_q.push_back(6);
    raise_if(32'h300);
    for (int i = 0; i < 10; i++) begin
      if (phase == P_ACT && k >= 2) break;
      step();
    end
    check_eq("mid_mov_pre", bus.mem_mov, 1'b1);
    #3 reset = 1'b0;
    #1;
    check_eq("mid_mov", bus.mem_mov, 1'b0);
    check_eq("mid_busy", bus.busy, 1'b0);
    check_eq("mid_if_ack", bus.if_ack, 1'b0);
    check_eq("mid_d_ack", bus.d_ack, 1'b0);
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    bus.mem_moc = 1'b0;
    dly_q.delete();
    rd_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    win_log.delete();
    base = n_done;
    dly_q.push_back(2);
    dly_q.push_back(1);
    dly_q.push_back(3);
    dly_q.push_back(2);
    req_mode = 2;
    wait_done(base + 4, 60);
    check_eq("rr_len", (win_log.size() >= 4), 1'b1);
    if (win_log.size() >= 4) begin
      check_eq("rr_0", win_log[0], GNT_IF);
      check_eq("rr_1", win_log[1], GNT_D);
      check_eq("rr_2", win_log[2], GNT_IF);
      check_eq("rr_3", win_log[3], GNT_D);
    end

    req_mode = 1;
    wait_done(n_done + 150, 4000);
    req_mode = 0;
    for (int i = 0; i < 12; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
